complete_stage: RTL and testbench

// Complete/retire stage of the 2-wide out-of-order RISC-V core; sits after dispatch/issue.

---
 rtl/complete_stage_pkg.sv | 40 ++++
 rtl/complete_stage_rob_buffer.sv | 120 ++++++++++++
 rtl/complete_stage.sv | 165 ++++++++++++++++
 tb/tb_complete_stage.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complete_stage_pkg.sv
// Shared types and constants for the complete/retire stage.
package complete_stage_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int NUM_PREGS  = 64;
    localparam int ROB_IDX_W  = 4;
    localparam int PREG_IDX_W = 6;
    localparam int CNT_W      = ROB_IDX_W + 1;

    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] PC_EMPTY = 7'h7F;

    localparam logic [1:0] ITYPE_OTHER = 2'd0;
    localparam logic [1:0] ITYPE_STORE = 2'd1;
    localparam logic [1:0] ITYPE_LOAD  = 2'd2;

    typedef struct packed {
        logic                  v;
        logic                  comp;
        logic [1:0]            instr_type;
        logic [4:0]            arch;
        logic [PREG_IDX_W-1:0] p_reg;
        logic [PREG_IDX_W-1:0] o_p_reg;
        logic [6:0]            pc;
        logic [31:0]           result;
    } rob_row;

    function automatic logic [1:0] instr_type_of(input logic [6:0] opcode);
        logic [1:0] t;
        t = ITYPE_OTHER;
        if (opcode == OP_STORE) begin
            t = ITYPE_STORE;
        end else if (opcode == OP_LOAD) begin
            t = ITYPE_LOAD;
        end
        return t;
    endfunction

endpackage

// File: rtl/complete_stage_rob_buffer.sv
// Circular 16-entry reorder buffer: allocation at the tail, completion marking,
// and in-order retirement of up to two entries per cycle from the head.
module rob_buffer
    import complete_stage_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_req,
    input  logic [1:0][PREG_IDX_W-1:0]      alloc_p_reg,
    input  logic [1:0][PREG_IDX_W-1:0]      alloc_o_p_reg,
    input  logic [1:0][4:0]                 alloc_arch,
    input  logic [1:0][6:0]                 alloc_opcode,
    input  logic [1:0][6:0]                 alloc_pc,
    input  logic [2:0]                      wb_valid,
    input  logic [2:0][ROB_IDX_W-1:0]       wb_rob,
    input  logic [2:0][31:0]                wb_data,
    output logic [ROB_IDX_W-1:0]            tail,
    output logic                            full,
    output logic [1:0]                      retire_fire,
    output logic [1:0]                      retire_flag,
    output logic [1:0][4:0]                 retire_index,
    output logic [1:0][31:0]                retire_result,
    output logic [1:0][PREG_IDX_W-1:0]      retire_fp
);

    rob_row               rob [ROB_DEPTH];
    logic [ROB_IDX_W-1:0] head;
    logic [ROB_IDX_W-1:0] head_p1;
    logic [CNT_W-1:0]     count;
    logic                 alloc_go;
    logic [1:0]           slot_used;
    logic [1:0]           n_alloc;
    logic [1:0]           n_retire;
    logic [ROB_IDX_W-1:0] slot_idx [2];
    rob_row               new_row  [2];
    rob_row               head_row [2];

    // Fewer than two free entries blocks a whole dispatch group.
    assign full = count > CNT_W'(ROB_DEPTH - 2);

    // Retire selection from start-of-cycle state and compacted slot placement for allocation.
    always_comb begin
        head_p1        = head + 1'b1;
        head_row[0]    = rob[head];
        head_row[1]    = rob[head_p1];
        retire_fire[0] = head_row[0].v && head_row[0].comp;
        retire_fire[1] = retire_fire[0] && head_row[1].v && head_row[1].comp;
        n_retire       = {1'b0, retire_fire[0]} + {1'b0, retire_fire[1]};
        alloc_go       = alloc_req && !full;
        for (int j = 0; j < 2; j++) begin
            slot_used[j] = alloc_go && (alloc_pc[j] != PC_EMPTY);
            new_row[j]   = '{v:          1'b1,
                             comp:       1'b0,
                             instr_type: instr_type_of(alloc_opcode[j]),
                             arch:       alloc_arch[j],
                             p_reg:      alloc_p_reg[j],
                             o_p_reg:    alloc_o_p_reg[j],
                             pc:         alloc_pc[j],
                             result:     32'd0};
        end
        n_alloc     = {1'b0, slot_used[0]} + {1'b0, slot_used[1]};
        slot_idx[0] = tail;
        slot_idx[1] = tail + ROB_IDX_W'(slot_used[0]);
    end

    // ROB entry updates, pointer/occupancy bookkeeping and registered retire outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob[i] <= '0;
            end
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            retire_flag   <= '0;
            retire_index  <= '0;
            retire_result <= '0;
            retire_fp     <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (wb_valid[k]) begin
                    rob[wb_rob[k]].comp   <= 1'b1;
                    rob[wb_rob[k]].result <= wb_data[k];
                end
            end
            if (retire_fire[0]) begin
                rob[head].v <= 1'b0;
            end
            if (retire_fire[1]) begin
                rob[head_p1].v <= 1'b0;
            end
            for (int j = 0; j < 2; j++) begin
                if (slot_used[j]) begin
                    rob[slot_idx[j]] <= new_row[j];
                end
            end
            head  <= head + ROB_IDX_W'(n_retire);
            tail  <= tail + ROB_IDX_W'(n_alloc);
            count <= count + CNT_W'(n_alloc) - CNT_W'(n_retire);
            for (int s = 0; s < 2; s++) begin
                retire_flag[s] <= retire_fire[s];
                if (retire_fire[s]) begin
                    retire_result[s] <= head_row[s].result;
                    if (head_row[s].instr_type == ITYPE_STORE) begin
                        retire_index[s] <= '0;
                        retire_fp[s]    <= '0;
                    end else begin
                        retire_index[s] <= head_row[s].arch;
                        retire_fp[s]    <= head_row[s].o_p_reg;
                    end
                end else begin
                    retire_index[s]  <= '0;
                    retire_result[s] <= '0;
                    retire_fp[s]     <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/complete_stage.sv
// Complete/retire stage: physical register file, result forwarding to dispatch,
// ROB wrapper and the program-done detector.
module complete_stage
    import complete_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_c1,
    input  logic [5:0]  result_dest_c1,
    input  logic        result_valid_c1,
    input  logic [3:0]  result_ROB_c1,
    input  logic [1:0]  result_FU_c1,
    input  logic [6:0]  result_pc_c1,
    input  logic [31:0] result_c2,
    input  logic [5:0]  result_dest_c2,
    input  logic        result_valid_c2,
    input  logic [3:0]  result_ROB_c2,
    input  logic [1:0]  result_FU_c2,
    input  logic [6:0]  result_pc_c2,
    input  logic [31:0] result_c3,
    input  logic [5:0]  result_dest_c3,
    input  logic        result_valid_c3,
    input  logic [3:0]  result_ROB_c3,
    input  logic [1:0]  result_FU_c3,
    input  logic [6:0]  result_pc_c3,
    input  logic        update_rob,
    input  logic [5:0]  rob_p_reg_1,
    input  logic [5:0]  o_rob_p_reg_1,
    input  logic [4:0]  rob_arch_1,
    input  logic [6:0]  rob_opcode_1,
    input  logic [6:0]  rob_pc_1,
    input  logic [5:0]  rob_p_reg_2,
    input  logic [5:0]  o_rob_p_reg_2,
    input  logic [4:0]  rob_arch_2,
    input  logic [6:0]  rob_opcode_2,
    input  logic [6:0]  rob_pc_2,
    input  logic [31:0] total_instr_count,
    output logic [3:0]  rob_tail,
    output logic        rob_full,
    output logic        forward_flag_1,
    output logic [5:0]  dest_R_1,
    output logic [31:0] forwarded_data_1,
    output logic        forward_flag_2,
    output logic [5:0]  dest_R_2,
    output logic [31:0] forwarded_data_2,
    output logic        forward_flag_3,
    output logic [5:0]  dest_R_3,
    output logic [31:0] forwarded_data_3,
    output logic        retire_flag_1,
    output logic [4:0]  retire_index_1,
    output logic [31:0] retire_result_1,
    output logic [5:0]  fp_ind_1,
    output logic        retire_flag_2,
    output logic [4:0]  retire_index_2,
    output logic [31:0] retire_result_2,
    output logic [5:0]  fp_ind_2,
    output logic        pr_flag,
    output logic [31:0] p_regs [NUM_PREGS]
);

    logic [2:0]                 wb_valid;
    logic [2:0][PREG_IDX_W-1:0] wb_dest;
    logic [2:0][ROB_IDX_W-1:0]  wb_rob;
    logic [2:0][31:0]           wb_data;
    logic [1:0]                 retire_fire;
    logic [1:0]                 ret_flag;
    logic [1:0][4:0]            ret_index;
    logic [1:0][31:0]           ret_result;
    logic [1:0][PREG_IDX_W-1:0] ret_fp;
    logic [31:0]                retired_cnt;
    logic                       unused_info;

    // FU id and PC travel with results for debug only.
    assign unused_info = ^{result_FU_c1, result_FU_c2, result_FU_c3,
                           result_pc_c1, result_pc_c2, result_pc_c3};

    assign wb_valid = {result_valid_c3, result_valid_c2, result_valid_c1};
    assign wb_dest  = {result_dest_c3, result_dest_c2, result_dest_c1};
    assign wb_rob   = {result_ROB_c3, result_ROB_c2, result_ROB_c1};
    assign wb_data  = {result_c3, result_c2, result_c1};

    rob_buffer u_rob (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (update_rob),
        .alloc_p_reg   ({rob_p_reg_2, rob_p_reg_1}),
        .alloc_o_p_reg ({o_rob_p_reg_2, o_rob_p_reg_1}),
        .alloc_arch    ({rob_arch_2, rob_arch_1}),
        .alloc_opcode  ({rob_opcode_2, rob_opcode_1}),
        .alloc_pc      ({rob_pc_2, rob_pc_1}),
        .wb_valid      (wb_valid),
        .wb_rob        (wb_rob),
        .wb_data       (wb_data),
        .tail          (rob_tail),
        .full          (rob_full),
        .retire_fire   (retire_fire),
        .retire_flag   (ret_flag),
        .retire_index  (ret_index),
        .retire_result (ret_result),
        .retire_fp     (ret_fp)
    );

    assign retire_flag_1   = ret_flag[0];
    assign retire_index_1  = ret_index[0];
    assign retire_result_1 = ret_result[0];
    assign fp_ind_1        = ret_fp[0];
    assign retire_flag_2   = ret_flag[1];
    assign retire_index_2  = ret_index[1];
    assign retire_result_2 = ret_result[1];
    assign fp_ind_2        = ret_fp[1];

    // Register file write; later lanes overwrite earlier ones and p0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                p_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (wb_valid[k] && (wb_dest[k] != '0)) begin
                    p_regs[wb_dest[k]] <= wb_data[k];
                end
            end
        end
    end

    // One-cycle forwarding copies for RS wakeup, zeroed on idle lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            forward_flag_1   <= 1'b0;
            dest_R_1         <= '0;
            forwarded_data_1 <= '0;
            forward_flag_2   <= 1'b0;
            dest_R_2         <= '0;
            forwarded_data_2 <= '0;
            forward_flag_3   <= 1'b0;
            dest_R_3         <= '0;
            forwarded_data_3 <= '0;
        end else begin
            forward_flag_1   <= result_valid_c1;
            dest_R_1         <= result_valid_c1 ? result_dest_c1 : '0;
            forwarded_data_1 <= result_valid_c1 ? result_c1 : '0;
            forward_flag_2   <= result_valid_c2;
            dest_R_2         <= result_valid_c2 ? result_dest_c2 : '0;
            forwarded_data_2 <= result_valid_c2 ? result_c2 : '0;
            forward_flag_3   <= result_valid_c3;
            dest_R_3         <= result_valid_c3 ? result_dest_c3 : '0;
            forwarded_data_3 <= result_valid_c3 ? result_c3 : '0;
        end
    end

    // Retirement count and sticky done flag, compared against the registered count.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            pr_flag     <= 1'b0;
        end else begin
            retired_cnt <= retired_cnt + 32'(retire_fire[0]) + 32'(retire_fire[1]);
            if ((total_instr_count != '0) && (retired_cnt == total_instr_count)) begin
                pr_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_complete_stage.sv
// Randomized and directed bench for complete_stage with a queue-based reference model.
module tb_complete_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ldat [3];
    logic [5:0]  ld   [3];
    logic        lv   [3];
    logic [3:0]  lrob [3];
    logic [1:0]  lfu  [3];
    logic [6:0]  lpc  [3];
    logic        update_rob;
    logic [5:0]  sp  [2];
    logic [5:0]  so  [2];
    logic [4:0]  sa  [2];
    logic [6:0]  sop [2];
    logic [6:0]  spc [2];
    logic [31:0] total_instr_count;

    logic [3:0]  rob_tail;
    logic        rob_full;
    logic        forward_flag_1, forward_flag_2, forward_flag_3;
    logic [5:0]  dest_R_1, dest_R_2, dest_R_3;
    logic [31:0] forwarded_data_1, forwarded_data_2, forwarded_data_3;
    logic        retire_flag_1, retire_flag_2;
    logic [4:0]  retire_index_1, retire_index_2;
    logic [31:0] retire_result_1, retire_result_2;
    logic [5:0]  fp_ind_1, fp_ind_2;
    logic        pr_flag;
    logic [31:0] p_regs [64];

    complete_stage dut (
        .clk(clk), .rst(rst),
        .result_c1(ldat[0]), .result_dest_c1(ld[0]), .result_valid_c1(lv[0]),
        .result_ROB_c1(lrob[0]), .result_FU_c1(lfu[0]), .result_pc_c1(lpc[0]),
        .result_c2(ldat[1]), .result_dest_c2(ld[1]), .result_valid_c2(lv[1]),
        .result_ROB_c2(lrob[1]), .result_FU_c2(lfu[1]), .result_pc_c2(lpc[1]),
        .result_c3(ldat[2]), .result_dest_c3(ld[2]), .result_valid_c3(lv[2]),
        .result_ROB_c3(lrob[2]), .result_FU_c3(lfu[2]), .result_pc_c3(lpc[2]),
        .update_rob(update_rob),
        .rob_p_reg_1(sp[0]), .o_rob_p_reg_1(so[0]), .rob_arch_1(sa[0]),
        .rob_opcode_1(sop[0]), .rob_pc_1(spc[0]),
        .rob_p_reg_2(sp[1]), .o_rob_p_reg_2(so[1]), .rob_arch_2(sa[1]),
        .rob_opcode_2(sop[1]), .rob_pc_2(spc[1]),
        .total_instr_count(total_instr_count),
        .rob_tail(rob_tail), .rob_full(rob_full),
        .forward_flag_1(forward_flag_1), .dest_R_1(dest_R_1), .forwarded_data_1(forwarded_data_1),
        .forward_flag_2(forward_flag_2), .dest_R_2(dest_R_2), .forwarded_data_2(forwarded_data_2),
        .forward_flag_3(forward_flag_3), .dest_R_3(dest_R_3), .forwarded_data_3(forwarded_data_3),
        .retire_flag_1(retire_flag_1), .retire_index_1(retire_index_1),
        .retire_result_1(retire_result_1), .fp_ind_1(fp_ind_1),
        .retire_flag_2(retire_flag_2), .retire_index_2(retire_index_2),
        .retire_result_2(retire_result_2), .fp_ind_2(fp_ind_2),
        .pr_flag(pr_flag), .p_regs(p_regs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    tail;
        logic          full;
        logic          pr;
        logic [2:0]    ff;
        logic [17:0]   dr;
        logic [95:0]   fd;
        logic [2047:0] pv;
    } status_t;

    typedef struct {
        int          stamp;
        int          slot;
        logic [4:0]  idx;
        logic [31:0] res;
        logic [5:0]  fp;
    } retire_t;

    typedef struct {
        logic [3:0]  idx;
        logic [4:0]  arch;
        logic [5:0]  o;
        bit          st;
        logic [31:0] res;
        bit          done;
    } entry_t;

    status_t     st_q[$];
    retire_t     ret_q[$];
    entry_t      mq[$];
    logic [31:0] m_preg [64];
    logic [3:0]  m_tail;
    logic [31:0] m_retired;
    logic        m_pr;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [6:0]  opc_tbl [4] = '{7'b0100011, 7'b0000011, 7'b0110011, 7'b0010011};

    status_t     cur;
    retire_t     rcur;
    int          bad;
    logic        flg;
    logic        exp_flg;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: program-order queue of in-flight instructions.
    task automatic model_step();
        status_t s;
        retire_t r;
        entry_t  e;
        int      nret;
        int      pre_size;
        nret = 0;
        s.ff = '0;
        s.dr = '0;
        s.fd = '0;
        if (rst) begin
            mq.delete();
            m_tail    = '0;
            m_retired = '0;
            m_pr      = 1'b0;
            for (int i = 0; i < 64; i++) m_preg[i] = '0;
        end else begin
            pre_size = mq.size();
            for (int sl = 0; sl < 2; sl++) begin
                if (sl == nret && nret < pre_size && mq[nret].done) begin
                    r.stamp = cyc + 1;
                    r.slot  = sl;
                    r.idx   = mq[nret].st ? 5'd0 : mq[nret].arch;
                    r.res   = mq[nret].res;
                    r.fp    = mq[nret].st ? 6'd0 : mq[nret].o;
                    ret_q.push_back(r);
                    nret++;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (lv[k]) begin
                    if (ld[k] != 6'd0) m_preg[ld[k]] = ldat[k];
                    foreach (mq[i]) begin
                        if (mq[i].idx == lrob[k]) begin
                            mq[i].done = 1'b1;
                            mq[i].res  = ldat[k];
                        end
                    end
                end
            end
            if (update_rob && pre_size <= 14) begin
                for (int j = 0; j < 2; j++) begin
                    if (spc[j] != 7'h7F) begin
                        e.idx  = m_tail;
                        e.arch = sa[j];
                        e.o    = so[j];
                        e.st   = (sop[j] == 7'b0100011);
                        e.res  = '0;
                        e.done = 1'b0;
                        mq.push_back(e);
                        m_tail = m_tail + 4'd1;
                    end
                end
            end
            repeat (nret) void'(mq.pop_front());
            if (total_instr_count != 0 && m_retired == total_instr_count) m_pr = 1'b1;
            m_retired = m_retired + 32'(nret);
            for (int k = 0; k < 3; k++) begin
                s.ff[k]        = lv[k];
                s.dr[k*6 +: 6]  = lv[k] ? ld[k] : 6'd0;
                s.fd[k*32 +: 32] = lv[k] ? ldat[k] : 32'd0;
            end
        end
        s.tail = m_tail;
        s.full = (mq.size() > 14);
        s.pr   = m_pr;
        for (int i = 0; i < 64; i++) s.pv[i*32 +: 32] = m_preg[i];
        st_q.push_back(s);
    endtask

    // Monitor: compares DUT outputs to the scoreboards after every active edge.
    always @(negedge clk) begin
        if (st_q.size() > 0) begin
            cur = st_q.pop_front();
            check("rob_tail", rob_tail, cur.tail);
            check("rob_full", rob_full, cur.full);
            check("pr_flag", pr_flag, cur.pr);
            check("forward_flags", {forward_flag_3, forward_flag_2, forward_flag_1}, cur.ff);
            check("dest_R", {dest_R_3, dest_R_2, dest_R_1}, cur.dr);
            check("forwarded_data", {forwarded_data_3, forwarded_data_2, forwarded_data_1}, cur.fd);
            bad = -1;
            for (int i = 63; i >= 0; i--) if (p_regs[i] !== cur.pv[i*32 +: 32]) bad = i;
            if (bad < 0) check("p_regs", p_regs[0], cur.pv[31:0]);
            else check($sformatf("p_regs[%0d]", bad), p_regs[bad], cur.pv[bad*32 +: 32]);
        end
        for (int s = 0; s < 2; s++) begin
            flg     = (s == 0) ? retire_flag_1 : retire_flag_2;
            exp_flg = (ret_q.size() > 0) && (ret_q[0].stamp == cyc) && (ret_q[0].slot == s);
            check($sformatf("retire_flag_%0d", s + 1), flg, exp_flg);
            if (exp_flg) begin
                rcur = ret_q.pop_front();
                check($sformatf("retire_index_%0d", s + 1), (s == 0) ? retire_index_1 : retire_index_2, rcur.idx);
                check($sformatf("retire_result_%0d", s + 1), (s == 0) ? retire_result_1 : retire_result_2, rcur.res);
                check($sformatf("fp_ind_%0d", s + 1), (s == 0) ? fp_ind_1 : fp_ind_2, rcur.fp);
            end
        end
    end

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            lv[k] = 1'b0; ld[k] = '0; ldat[k] = '0; lrob[k] = '0; lfu[k] = '0; lpc[k] = '0;
        end
        update_rob = 1'b0;
        for (int j = 0; j < 2; j++) begin
            sp[j] = '0; so[j] = '0; sa[j] = '0; sop[j] = 7'b0110011; spc[j] = 7'h7F;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic set_slot(input int j, input logic [5:0] p, input logic [5:0] o,
                            input logic [4:0] a, input logic [6:0] op, input logic [6:0] pc);
        sp[j] = p; so[j] = o; sa[j] = a; sop[j] = op; spc[j] = pc;
    endtask

    task automatic set_lane(input int k, input logic [5:0] d, input logic [31:0] v, input logic [3:0] r);
        lv[k] = 1'b1; ld[k] = d; ldat[k] = v; lrob[k] = r;
    endtask

    // Completes up to three pending entries, oldest first.
    task automatic complete_pending(output int n);
        n = 0;
        foreach (mq[i]) begin
            if (!mq[i].done && n < 3) begin
                set_lane(n, 6'($urandom_range(1, 63)), $urandom, mq[i].idx);
                n++;
            end
        end
    endtask

    task automatic rand_inputs();
        int cand[$];
        int pick;
        update_rob = ($urandom_range(0, 99) < 60);
        for (int j = 0; j < 2; j++) begin
            set_slot(j, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                     opc_tbl[$urandom_range(0, 3)],
                     ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 126)));
        end
        foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
        for (int k = 0; k < 3; k++) begin
            if (cand.size() > 0 && $urandom_range(0, 99) < 55) begin
                pick = $urandom_range(0, cand.size() - 1);
                set_lane(k, 6'($urandom_range(0, 63)), $urandom, mq[cand[pick]].idx);
                cand.delete(pick);
            end else begin
                lv[k] = 1'b0; ld[k] = 6'($urandom); ldat[k] = $urandom; lrob[k] = 4'($urandom);
            end
            lfu[k] = 2'($urandom);
            lpc[k] = 7'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        total_instr_count = '0;
        idle_inputs();
        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_rob_tail", rob_tail, 4'd0);
        check("reset_rob_full", rob_full, 1'b0);
        check("reset_p_regs5", p_regs[5], 32'd0);
        check("reset_retire_flag_1", retire_flag_1, 1'b0);
        check("reset_forward_flag_1", forward_flag_1, 1'b0);
        check("reset_pr_flag", pr_flag, 1'b0);

        // Single alloc, complete, retire
        update_rob = 1'b1;
        set_slot(0, 6'd33, 6'd3, 5'd3, 7'b0110011, 7'h10);
        step();
        set_lane(0, 6'd33, 32'h2A, 4'd0);
        step();
        check("t2_forward_flag_1", forward_flag_1, 1'b1);
        check("t2_dest_R_1", dest_R_1, 6'd33);
        step();
        check("t2_retire_flag_1", retire_flag_1, 1'b1);
        check("t2_retire_index_1", retire_index_1, 5'd3);
        check("t2_retire_result_1", retire_result_1, 32'h2A);
        check("t2_fp_ind_1", fp_ind_1, 6'd3);

        // Out-of-order completion
        update_rob = 1'b1;
        set_slot(0, 6'd34, 6'd4, 5'd4, 7'b0110011, 7'h11);
        set_slot(1, 6'd35, 6'd5, 5'd5, 7'b0000011, 7'h12);
        step();
        set_lane(0, 6'd35, 32'h22, 4'd2);
        step();
        step();
        check("t3_no_early_retire", retire_flag_1, 1'b0);
        set_lane(1, 6'd34, 32'h11, 4'd1);
        step();
        step();
        check("t3_both_retire", {retire_flag_2, retire_flag_1}, 2'b11);
        check("t3_retire_result_1", retire_result_1, 32'h11);
        check("t3_retire_result_2", retire_result_2, 32'h22);

        // Fill, overflow attempt and wrap
        for (int i = 0; i < 9; i++) begin
            update_rob = 1'b1;
            set_slot(0, 6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)), 5'($urandom_range(1, 31)),
                     opc_tbl[i % 4], 7'(i * 2));
            set_slot(1, 6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)), 5'($urandom_range(1, 31)),
                     opc_tbl[(i + 1) % 4], 7'(i * 2 + 1));
            step();
            if (i == 7) check("t4_full_after_16", rob_full, 1'b1);
        end
        check("t4_tail_after_drop", rob_tail, 4'd3);
        for (int it = 0; it < 8; it++) begin
            complete_pending(n);
            step();
        end
        for (int it = 0; it < 10; it++) step();
        check("t4_tail_wrapped", rob_tail, 4'd3);
        check("t4_not_full", rob_full, 1'b0);

        // Triple writeback and same-destination priority
        set_lane(0, 6'd40, 32'hAAAA_0040, 4'd5);
        set_lane(1, 6'd41, 32'hBBBB_0041, 4'd6);
        set_lane(2, 6'd0,  32'hCCCC_0000, 4'd7);
        step();
        check("t5_preg40", p_regs[40], 32'hAAAA_0040);
        check("t5_preg41", p_regs[41], 32'hBBBB_0041);
        check("t5_preg0", p_regs[0], 32'd0);
        set_lane(0, 6'd42, 32'h1111_1111, 4'd8);
        set_lane(2, 6'd42, 32'h3333_3333, 4'd9);
        step();
        check("t5_preg42_lane3_wins", p_regs[42], 32'h3333_3333);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end
        for (int it = 0; it < 8; it++) begin
            complete_pending(n);
            step();
        end
        for (int it = 0; it < 10; it++) step();

        // Done detection
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_instr_count = 32'd4;
        for (int i = 0; i < 2; i++) begin
            update_rob = 1'b1;
            set_slot(0, 6'(10 + i), 6'(20 + i), 5'(1 + i), 7'b0110011, 7'(i * 2));
            set_slot(1, 6'(12 + i), 6'(22 + i), 5'(3 + i), 7'b0100011, 7'(i * 2 + 1));
            step();
        end
        check("t6_pr_flag_low", pr_flag, 1'b0);
        for (int it = 0; it < 2; it++) begin
            complete_pending(n);
            step();
        end
        for (int it = 0; it < 4; it++) step();
        check("t6_pr_flag_set", pr_flag, 1'b1);
        for (int it = 0; it < 3; it++) step();
        check("t6_pr_flag_sticky", pr_flag, 1'b1);

        step();
        check("scoreboard_drained", ret_q.size(), 0);
        @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
